// File: rtl/cic_pkg.sv
// Shared constants for the 3rd-order CIC decimator: filter order and
// register width derived from the decimation exponent.
package cic_pkg;
    localparam int CIC_ORDER = 3;

    // Full-scale gain R^N = 2^(N*DEC_LOG2) fits as a positive signed value with two spare bits.
    function automatic int cic_width(input int dec_log2);
        return CIC_ORDER * dec_log2 + 2;
    endfunction
endpackage

// File: rtl/cic_decimator_if.sv
// Comparator/feedback pin pair plus the decimated sample stream.
interface cic_decimator_if #(
    parameter int OUT_WIDTH = 12
);
    logic                 comp_in;
    logic                 fb_out;
    logic [OUT_WIDTH-1:0] sample_out;
    logic                 sample_valid;

    modport master (input comp_in, output fb_out, output sample_out, output sample_valid);
    modport slave  (output comp_in, input fb_out, input sample_out, input sample_valid);
endinterface

// File: rtl/comp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
module comp_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/cic_decimator.sv
// Sigma-delta front end: comparator synchronizer/feedback bit and a
// 3rd-order CIC decimator producing signed samples every 2^DEC_LOG2 cycles.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int DEC_LOG2  = 6,
    parameter int OUT_WIDTH = 12
) (
    input logic             clk_in,
    input logic             rst,
    cic_decimator_if.master bus
);
    localparam int W = cic_width(DEC_LOG2);
    localparam logic [W-1:0]        ONE      = W'(1);
    localparam logic [DEC_LOG2-1:0] CNT_LAST = '1;

    logic                          fb;
    logic [W-1:0]                  x;
    logic [CIC_ORDER-1:0][W-1:0]   integ;
    logic [CIC_ORDER-1:0][W-1:0]   comb;
    logic [CIC_ORDER-1:0][W-1:0]   dly;
    logic [DEC_LOG2-1:0]           cnt;
    logic                          dec_stb;
    logic [CIC_ORDER:1]            vld_pipe;

    comp_sync u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (bus.comp_in),
        .q      (fb)
    );

    assign bus.fb_out = fb;
    assign x          = fb ? ONE : '1;

    // Integrators wrap freely; the combs cancel the wrap exactly.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            integ <= '0;
        end else begin
            integ[0] <= integ[0] + x;
            for (int k = 1; k < CIC_ORDER; k++)
                integ[k] <= integ[k] + integ[k-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + 1'b1;
    end

    assign dec_stb = (cnt == CNT_LAST);

    // Comb k fires on its own valid bit, so the chain is a strobe pipeline
    // and the last stage holds its value between strobes.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            comb     <= '0;
            dly      <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[CIC_ORDER-1:1], dec_stb};
            if (dec_stb) begin
                comb[0] <= integ[CIC_ORDER-1] - dly[0];
                dly[0]  <= integ[CIC_ORDER-1];
            end
            for (int k = 1; k < CIC_ORDER; k++) begin
                if (vld_pipe[k]) begin
                    comb[k] <= comb[k-1] - dly[k];
                    dly[k]  <= comb[k-1];
                end
            end
        end
    end

    assign bus.sample_out   = comb[CIC_ORDER-1][W-1 -: OUT_WIDTH];
    assign bus.sample_valid = vld_pipe[CIC_ORDER];

    logic unused_lsbs;
    assign unused_lsbs = ^comb[CIC_ORDER-1];
endmodule

// File: tb/tb_cic_decimator.sv
// Drives a default (R=64, 12-bit) and a minimal (R=2, 5-bit) decimator from
// one comparator stream and checks both against a direct-form CIC model.
module tb_cic_decimator;
    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    logic comp   = 1'b0;

    always #5 clk_in = ~clk_in;

    cic_decimator_if #(.OUT_WIDTH(12)) ifa ();
    cic_decimator_if #(.OUT_WIDTH(5))  ifb ();
    assign ifa.comp_in = comp;
    assign ifb.comp_in = comp;

    cic_decimator #(.DEC_LOG2(6), .OUT_WIDTH(12)) dut_a (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (ifa)
    );
    cic_decimator #(.DEC_LOG2(1), .OUT_WIDTH(5)) dut_b (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (ifb)
    );

    int checks = 0;
    int fails  = 0;

    // Model state: cycle index since reset, comparator and +/-1 histories.
    int n      = 0;
    bit prev_r = 1'b1;
    bit ch[$];
    int xh[$];
    int hA[];
    int hB[];
    int st[2];
    int held[2];

    // Impulse response of (1 + z^-1 + ... + z^-(R-1))^3.
    task automatic build_h(input int R, input bit b);
        int h2[];
        int h3[];
        h2 = new[2*R-1];
        h3 = new[3*R-2];
        for (int a = 0; a < R; a++)
            for (int c = 0; c < R; c++) h2[a+c] += 1;
        for (int i = 0; i < 2*R-1; i++)
            for (int c = 0; c < R; c++) h3[i+c] += h2[i];
        if (b) hB = h3;
        else   hA = h3;
    endtask

    // Filter output for a decimation instant t; integrator and comb registers
    // add a 3-cycle lag between the feedback bit and the captured sum.
    function automatic int ref_y(input bit b, input int t);
        int acc;
        int len;
        acc = 0;
        len = b ? hB.size() : hA.size();
        for (int j = 0; j < len; j++) begin
            int k;
            k = t - 3 - j;
            if (k >= 0) acc += (b ? hB[j] : hA[j]) * xh[k];
        end
        return acc;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, n, obs, exp);
        end
    endtask

    task automatic eval_dut(input bit b, input logic vld, input logic signed [31:0] so);
        int R;
        int sh;
        bit ev;
        R  = b ? 2 : 64;
        sh = b ? 0 : 8;
        ev = (n >= 3) && (((n - 3) % R) == R - 1);
        chk(b ? "valid_b" : "valid_a", 32'(vld), 32'(ev));
        if (ev) begin
            st[b]++;
            if (st[b] >= 4) held[b] = ref_y(b, n - 3) >>> sh;
        end
        // The first three strobes are filter transients and are not scored.
        if (st[b] == 0 || st[b] >= 4)
            chk(b ? "sample_b" : "sample_a", so, held[b]);
    endtask

    task automatic step(input bit c, input bit r);
        int efb;
        @(posedge clk_in);
        #1;
        comp = c;
        rst  = r;
        @(negedge clk_in);
        if (prev_r) begin
            n = 0;
            ch.delete();
            xh.delete();
            st   = '{0, 0};
            held = '{0, 0};
        end
        efb = (n < 2) ? 0 : int'(ch[n-2]);
        chk("fb_a", 32'(ifa.fb_out), efb);
        chk("fb_b", 32'(ifb.fb_out), efb);
        eval_dut(1'b0, ifa.sample_valid, $signed(ifa.sample_out));
        eval_dut(1'b1, ifb.sample_valid, $signed(ifb.sample_out));
        ch.push_back(c);
        xh.push_back(efb != 0 ? 1 : -1);
        n++;
        prev_r = r;
    endtask

    initial begin
        build_h(64, 1'b0);
        build_h(2, 1'b1);

        repeat (3) step(1'b0, 1'b1);
        repeat (600) step(1'b1, 1'b0);
        repeat (600) step(1'b0, 1'b0);
        repeat (3000) step(1'($urandom_range(1, 0)), 1'b0);
        for (int i = 0; i < 6000; i++) step((i % 2) == 0, 1'b0);

        // Reset lands one cycle after a decimation strobe of the R=64 instance.
        while ((n % 64) != 0) step(1'($urandom_range(1, 0)), 1'b0);
        repeat (2) step(1'($urandom_range(1, 0)), 1'b1);

        repeat (400) step(1'b1, 1'b0);
        repeat (2000) step(1'($urandom_range(1, 0)), 1'b0);
        for (int i = 0; i < 2000; i++) step((i % 2) == 1, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
